rom_burst_arbiter: RTL and testbench

//   Shares one combinational 8x8 ROM (rom8x8) between two requesters, e.g. fetch and data-load.

---
 rtl/rom_burst_arbiter_pkg.sv | 13 +
 rtl/rom_burst_arbiter_if.sv | 46 ++++
 rtl/rom_burst_arbiter_rr_arb2.sv | 19 +
 rtl/rom_burst_arbiter.sv | 98 +++++++++
 tb/tb_rom_burst_arbiter.sv | 190 +++++++++++++++++++
 5 files changed

// File: rtl/rom_burst_arbiter_pkg.sv
// Shared definitions for the two-requester ROM burst arbiter.
package rom_arb_pkg;

    localparam int AW_DEF = 3;
    localparam int DW_DEF = 8;

    localparam logic [0:0] ST_IDLE = 1'b0;
    localparam logic [0:0] ST_BEAT = 1'b1;

    localparam logic REQ0 = 1'b0;
    localparam logic REQ1 = 1'b1;

endpackage

// File: rtl/rom_burst_arbiter_if.sv
// Request and response handshake bundle between the requesters/consumer and the arbiter.
interface rom_burst_arbiter_if
    import rom_arb_pkg::*;
#(
    parameter int AW = AW_DEF,
    parameter int DW = DW_DEF
);

    logic          req0_valid;
    logic [AW-1:0] req0_addr;
    logic [AW-1:0] req0_len;
    logic          req0_ready;
    logic          req1_valid;
    logic [AW-1:0] req1_addr;
    logic [AW-1:0] req1_len;
    logic          req1_ready;
    logic          rsp_valid;
    logic [DW-1:0] rsp_data;
    logic          rsp_id;
    logic          rsp_last;
    logic          rsp_ready;
    logic          busy;

    // Requester/consumer side
    modport master (
        output req0_valid, req0_addr, req0_len,
        input  req0_ready,
        output req1_valid, req1_addr, req1_len,
        input  req1_ready,
        input  rsp_valid, rsp_data, rsp_id, rsp_last,
        output rsp_ready,
        input  busy
    );

    // Arbiter side
    modport slave (
        input  req0_valid, req0_addr, req0_len,
        output req0_ready,
        input  req1_valid, req1_addr, req1_len,
        output req1_ready,
        output rsp_valid, rsp_data, rsp_id, rsp_last,
        input  rsp_ready,
        output busy
    );

endinterface

// File: rtl/rom_burst_arbiter_rr_arb2.sv
// Two-way round-robin winner select: a lone requester wins, a tie goes to the
// requester that was not granted last.
module rr_arb2
    import rom_arb_pkg::*;
(
    input  logic valid0,
    input  logic valid1,
    input  logic rr_last,
    output logic grant0,
    output logic grant1
);

    // Pick at most one winner from the current valids and the last owner
    always_comb begin
        grant0 = valid0 && (!valid1 || (rr_last == REQ1));
        grant1 = valid1 && (!valid0 || (rr_last == REQ0));
    end

endmodule

// File: rtl/rom_burst_arbiter.sv
// Streams bursts out of an external combinational ROM for one of two requesters.
// A granted burst runs to completion; the address wraps modulo the ROM depth.
module rom_burst_arbiter
    import rom_arb_pkg::*;
#(
    parameter int AW = AW_DEF,
    parameter int DW = DW_DEF
)(
    input  logic                 clk,
    input  logic                 rst_n,
    rom_burst_arbiter_if.slave   bus,
    output logic [AW-1:0]        rom_a,
    input  logic [DW-1:0]        rom_d
);

    logic [0:0]    state_q,   state_d;
    logic [AW-1:0] rom_a_q,   rom_a_d;
    logic [AW-1:0] cnt_q,     cnt_d;
    logic          owner_q,   owner_d;
    logic          rr_last_q, rr_last_d;
    logic          grant0,    grant1;
    logic          in_beat;

    rr_arb2 u_rr_arb2 (
        .valid0  (bus.req0_valid),
        .valid1  (bus.req1_valid),
        .rr_last (rr_last_q),
        .grant0  (grant0),
        .grant1  (grant1)
    );

    // Next-state logic: accept a winner in IDLE, step through beats in BEAT
    always_comb begin
        state_d   = state_q;
        rom_a_d   = rom_a_q;
        cnt_d     = cnt_q;
        owner_d   = owner_q;
        rr_last_d = rr_last_q;
        case (state_q)
            ST_IDLE: begin
                if (grant0) begin
                    rom_a_d   = bus.req0_addr;
                    cnt_d     = bus.req0_len;
                    owner_d   = REQ0;
                    rr_last_d = REQ0;
                    state_d   = ST_BEAT;
                end else if (grant1) begin
                    rom_a_d   = bus.req1_addr;
                    cnt_d     = bus.req1_len;
                    owner_d   = REQ1;
                    rr_last_d = REQ1;
                    state_d   = ST_BEAT;
                end
            end
            default: begin
                if (bus.rsp_ready) begin
                    if (cnt_q == '0) begin
                        state_d = ST_IDLE;
                    end else begin
                        rom_a_d = rom_a_q + AW'(1);
                        cnt_d   = cnt_q - AW'(1);
                    end
                end
            end
        endcase
    end

    // State registers; rr_last resets to requester 1 so requester 0 wins the first tie
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= ST_IDLE;
            rom_a_q   <= '0;
            cnt_q     <= '0;
            owner_q   <= REQ0;
            rr_last_q <= REQ1;
        end else begin
            state_q   <= state_d;
            rom_a_q   <= rom_a_d;
            cnt_q     <= cnt_d;
            owner_q   <= owner_d;
            rr_last_q <= rr_last_d;
        end
    end

    // Output decode: ready only while idle, response fields only while beating
    always_comb begin
        in_beat        = (state_q == ST_BEAT);
        bus.req0_ready = !in_beat && grant0;
        bus.req1_ready = !in_beat && grant1;
        bus.rsp_valid  = in_beat;
        bus.rsp_data   = in_beat ? rom_d : '0;
        bus.rsp_id     = owner_q;
        bus.rsp_last   = in_beat && (cnt_q == '0);
        bus.busy       = in_beat;
        rom_a          = rom_a_q;
    end

endmodule

// File: tb/tb_rom_burst_arbiter.sv
// Directed testbench for rom_burst_arbiter with a 0x10+addr ROM model.
module tb_rom_burst_arbiter;

    logic       clk;
    logic       rst_n;
    logic [2:0] rom_a;
    logic [7:0] rom_d;
    int         vectors;
    int         miscompares;

    rom_burst_arbiter_if #(.AW(3), .DW(8)) bus ();

    rom_burst_arbiter #(.AW(3), .DW(8)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus),
        .rom_a (rom_a),
        .rom_d (rom_d)
    );

    // Combinational ROM: each location holds 0x10 plus its address
    assign rom_d = 8'h10 + {5'b0, rom_a};

    // Free-running clock
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Hard stop in case the sequence ever stalls
    initial begin
        #200000;
        $display("[TB] FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic checkOutput(input string tag, input logic [7:0] observed, input logic [7:0] expected);
        vectors++;
        assert (observed === expected)
        else begin
            miscompares++;
            $error("[TB] FAIL %s observed=%h expected=%h", tag, observed, expected);
        end
    endtask

    task automatic applyStimulus(input logic v0, input logic [2:0] a0, input logic [2:0] l0,
                                 input logic v1, input logic [2:0] a1, input logic [2:0] l1,
                                 input logic rdy);
        bus.req0_valid = v0;
        bus.req0_addr  = a0;
        bus.req0_len   = l0;
        bus.req1_valid = v1;
        bus.req1_addr  = a1;
        bus.req1_len   = l1;
        bus.rsp_ready  = rdy;
        #1;
    endtask

    task automatic checkBeat(input string tag, input logic [7:0] data, input logic id, input logic last);
        checkOutput({tag, "_valid"}, 8'(bus.rsp_valid), 8'h01);
        checkOutput({tag, "_data"},  bus.rsp_data,       data);
        checkOutput({tag, "_id"},    8'(bus.rsp_id),     8'(id));
        checkOutput({tag, "_last"},  8'(bus.rsp_last),   8'(last));
    endtask

    task automatic checkIdle(input string tag);
        checkOutput({tag, "_valid"}, 8'(bus.rsp_valid), 8'h00);
        checkOutput({tag, "_busy"},  8'(bus.busy),      8'h00);
        checkOutput({tag, "_last"},  8'(bus.rsp_last),  8'h00);
    endtask

    // Directed sequence
    initial begin
        logic [7:0] exp3 [4];
        vectors     = 0;
        miscompares = 0;
        exp3[0] = 8'h16; exp3[1] = 8'h17; exp3[2] = 8'h10; exp3[3] = 8'h11;

        // Reset with no requests
        rst_n = 1'b0;
        applyStimulus(1'b0, 3'd0, 3'd0, 1'b0, 3'd0, 3'd0, 1'b0);
        #1;
        checkIdle("rst");
        checkOutput("rst_rdy0", 8'(bus.req0_ready), 8'h00);
        checkOutput("rst_rdy1", 8'(bus.req1_ready), 8'h00);
        checkOutput("rst_id",   8'(bus.rsp_id),     8'h00);
        checkOutput("rst_roma", 8'(rom_a),          8'h00);
        tick();
        rst_n = 1'b1;
        repeat (3) tick();
        checkIdle("idle_norq");

        // Single-beat burst from requester 0
        applyStimulus(1'b1, 3'd2, 3'd0, 1'b0, 3'd0, 3'd0, 1'b1);
        checkOutput("t2_rdy0", 8'(bus.req0_ready), 8'h01);
        checkOutput("t2_rdy1", 8'(bus.req1_ready), 8'h00);
        tick();
        applyStimulus(1'b0, 3'd0, 3'd0, 1'b0, 3'd0, 3'd0, 1'b1);
        checkOutput("t2_rdy0_off", 8'(bus.req0_ready), 8'h00);
        checkOutput("t2_roma", 8'(rom_a), 8'h02);
        checkBeat("t2_b0", 8'h12, 1'b0, 1'b1);
        tick();
        checkIdle("t2_end");

        // Four-beat burst from requester 1 wrapping past address 7
        applyStimulus(1'b0, 3'd0, 3'd0, 1'b1, 3'd6, 3'd3, 1'b1);
        checkOutput("t3_rdy1", 8'(bus.req1_ready), 8'h01);
        tick();
        applyStimulus(1'b0, 3'd0, 3'd0, 1'b0, 3'd0, 3'd0, 1'b1);
        for (int i = 0; i < 4; i++) begin
            checkBeat($sformatf("t3_b%0d", i), exp3[i], 1'b1, (i == 3));
            tick();
        end
        checkIdle("t3_end");

        // Fresh reset, then ties resolved round-robin
        rst_n = 1'b0;
        #1;
        rst_n = 1'b1;
        applyStimulus(1'b1, 3'd0, 3'd1, 1'b1, 3'd4, 3'd1, 1'b1);
        checkOutput("t4_tie1_rdy0", 8'(bus.req0_ready), 8'h01);
        checkOutput("t4_tie1_rdy1", 8'(bus.req1_ready), 8'h00);
        tick();
        checkOutput("t4_beat_rdy1", 8'(bus.req1_ready), 8'h00);
        checkBeat("t4_a0", 8'h10, 1'b0, 1'b0);
        tick();
        checkBeat("t4_a1", 8'h11, 1'b0, 1'b1);
        tick();
        checkOutput("t4_tie2_rdy0", 8'(bus.req0_ready), 8'h00);
        checkOutput("t4_tie2_rdy1", 8'(bus.req1_ready), 8'h01);
        tick();
        applyStimulus(1'b0, 3'd0, 3'd0, 1'b0, 3'd0, 3'd0, 1'b1);
        checkBeat("t4_b0", 8'h14, 1'b1, 1'b0);
        tick();
        checkBeat("t4_b1", 8'h15, 1'b1, 1'b1);
        tick();
        checkIdle("t4_end");

        // Backpressure on the second beat of a three-beat burst
        applyStimulus(1'b1, 3'd0, 3'd2, 1'b0, 3'd0, 3'd0, 1'b1);
        checkOutput("t5_rdy0", 8'(bus.req0_ready), 8'h01);
        tick();
        applyStimulus(1'b0, 3'd0, 3'd0, 1'b0, 3'd0, 3'd0, 1'b1);
        checkBeat("t5_b0", 8'h10, 1'b0, 1'b0);
        tick();
        applyStimulus(1'b0, 3'd0, 3'd0, 1'b0, 3'd0, 3'd0, 1'b0);
        for (int i = 0; i < 3; i++) begin
            checkBeat($sformatf("t5_hold%0d", i), 8'h11, 1'b0, 1'b0);
            checkOutput($sformatf("t5_hold%0d_roma", i), 8'(rom_a), 8'h01);
            tick();
        end
        applyStimulus(1'b0, 3'd0, 3'd0, 1'b0, 3'd0, 3'd0, 1'b1);
        checkBeat("t5_b1", 8'h11, 1'b0, 1'b0);
        tick();
        checkBeat("t5_b2", 8'h12, 1'b0, 1'b1);
        tick();
        checkIdle("t5_end");

        // Reset during the second beat of a four-beat burst
        applyStimulus(1'b1, 3'd4, 3'd3, 1'b0, 3'd0, 3'd0, 1'b1);
        tick();
        applyStimulus(1'b0, 3'd0, 3'd0, 1'b0, 3'd0, 3'd0, 1'b1);
        checkBeat("t6_b0", 8'h14, 1'b0, 1'b0);
        tick();
        checkBeat("t6_b1", 8'h15, 1'b0, 1'b0);
        rst_n = 1'b0;
        #1;
        checkIdle("t6_abort");
        checkOutput("t6_abort_roma", 8'(rom_a), 8'h00);
        tick();
        rst_n = 1'b1;
        checkIdle("t6_after");
        applyStimulus(1'b0, 3'd0, 3'd0, 1'b1, 3'd7, 3'd0, 1'b1);
        checkOutput("t6_rdy1", 8'(bus.req1_ready), 8'h01);
        tick();
        applyStimulus(1'b0, 3'd0, 3'd0, 1'b0, 3'd0, 3'd0, 1'b1);
        checkBeat("t6_new", 8'h17, 1'b1, 1'b1);
        tick();
        checkIdle("t6_end");

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
